am2940_dma_sequencer: RTL and testbench

Sequencer that programs and steps the Am2940 DMA address generator through one block transfer. It sits between the system-level DMA request logic and the `instruction_decoder`/counter datapath. It drives the 3-bit instruction code I[2:0] and the load-data bus, and paces the counter-enable instruction against a memory-side req/ack handshake. It also cross-checks the generator's DONE flag against its own beat count.

---
 rtl/am2940_pkg.sv | 26 ++
 rtl/am2940_beat_counter.sv | 34 +++
 rtl/am2940_dma_sequencer.sv | 145 ++++++++++++++
 tb/tb_am2940_dma_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/am2940_pkg.sv
// Shared Am2940 instruction codes and the DMA sequencer state encoding.
package am2940_pkg;

    localparam logic [2:0] InstrWrcr = 3'b000;
    localparam logic [2:0] InstrRdcr = 3'b001;
    localparam logic [2:0] InstrRdwc = 3'b010;
    localparam logic [2:0] InstrRdac = 3'b011;
    localparam logic [2:0] InstrRein = 3'b100;
    localparam logic [2:0] InstrLdar = 3'b101;
    localparam logic [2:0] InstrLdwc = 3'b110;
    localparam logic [2:0] InstrEnct = 3'b111;

    // Done mode in which the generator's DONE must stay low until the final word.
    localparam logic [1:0] DoneModeWc = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StWrCr,
        StLdAr,
        StLdWc,
        StReinit,
        StRun,
        StFinish
    } state_e;

endpackage

// File: rtl/am2940_beat_counter.sv
// Loadable down-counter of remaining transfer beats; a loaded 0 counts 2^AW beats.
module am2940_beat_counter #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          dec,
    output logic          last
);

    logic [AW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec) begin
            count_d = count_q - AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == AW'(1));

endmodule

// File: rtl/am2940_dma_sequencer.sv
// Programs the Am2940 address generator for one block transfer and paces ENCT
// against the memory req/ack handshake, cross-checking the generator's DONE flag.
module am2940_dma_sequencer
    import am2940_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cfg_reinit,
    input  logic [2:0]    cfg_cr,
    input  logic [AW-1:0] cfg_addr,
    input  logic [AW-1:0] cfg_wc,
    input  logic          abort,
    input  logic          gen_done,
    output logic [2:0]    instr,
    output logic [AW-1:0] load_data,
    output logic          load_oe,
    output logic          xfer_req,
    input  logic          xfer_ack,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          err
);

    state_e        state_q, state_d;
    logic [2:0]    cr_q;
    logic [AW-1:0] addr_q, wc_q;
    logic          err_q, aborted_q;

    logic cap, cnt_dec, last, err_set, err_clr, abort_hit;

    am2940_beat_counter #(
        .AW(AW)
    ) u_beat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cap),
        .load_val (cfg_wc),
        .dec      (cnt_dec),
        .last     (last)
    );

    always_comb begin
        state_d   = state_q;
        instr     = InstrRdcr;
        load_data = '0;
        load_oe   = 1'b0;
        xfer_req  = 1'b0;
        cap       = 1'b0;
        cnt_dec   = 1'b0;
        done      = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        abort_hit = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cap     = 1'b1;
                    err_clr = 1'b1;
                    state_d = cfg_reinit ? StReinit : StWrCr;
                end
            end
            StWrCr: begin
                instr     = InstrWrcr;
                load_data = AW'(cr_q);
                load_oe   = 1'b1;
                state_d   = StLdAr;
            end
            StLdAr: begin
                instr     = InstrLdar;
                load_data = addr_q;
                load_oe   = 1'b1;
                state_d   = StLdWc;
            end
            StLdWc: begin
                instr     = InstrLdwc;
                load_data = wc_q;
                load_oe   = 1'b1;
                state_d   = StRun;
            end
            StReinit: begin
                instr   = InstrRein;
                state_d = StRun;
            end
            StRun: begin
                xfer_req = 1'b1;
                if (xfer_ack && !abort) begin
                    instr   = InstrEnct;
                    cnt_dec = 1'b1;
                    if (last) begin
                        state_d = StFinish;
                    end
                end
                // DONE before the final ENCT means generator and sequencer disagree.
                if (cr_q[1:0] == DoneModeWc && gen_done && !abort && !(xfer_ack && last)) begin
                    err_set = 1'b1;
                end
            end
            StFinish: begin
                done    = !abort;
                err_set = !gen_done && !abort;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort && state_q != StIdle) begin
            state_d   = StIdle;
            abort_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cr_q      <= '0;
            addr_q    <= '0;
            wc_q      <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aborted_q <= abort_hit;
            if (cap) begin
                cr_q   <= cfg_cr;
                addr_q <= cfg_addr;
                wc_q   <= cfg_wc;
            end
            if (err_clr) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy    = (state_q != StIdle);
    assign aborted = aborted_q;
    assign err     = err_q;

endmodule

// File: tb/tb_am2940_dma_sequencer.sv
// Directed vector bench for am2940_dma_sequencer: per-cycle table plus a zero-count run.
module tb_am2940_dma_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, cfg_reinit, abort, gen_done, xfer_ack;
    logic [2:0] cfg_cr;
    logic [7:0] cfg_addr, cfg_wc;
    logic [2:0] instr;
    logic [7:0] load_data;
    logic       load_oe, xfer_req, busy, done, aborted, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    am2940_dma_sequencer #(
        .AW(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_reinit (cfg_reinit),
        .cfg_cr     (cfg_cr),
        .cfg_addr   (cfg_addr),
        .cfg_wc     (cfg_wc),
        .abort      (abort),
        .gen_done   (gen_done),
        .instr      (instr),
        .load_data  (load_data),
        .load_oe    (load_oe),
        .xfer_req   (xfer_req),
        .xfer_ack   (xfer_ack),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .err        (err)
    );

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       reinit;
        logic [2:0] cr;
        logic [7:0] addr;
        logic [7:0] wc;
        logic       abort;
        logic       gd;
        logic       ack;
        logic [16:0] exp;  // {instr, load_data, load_oe, xfer_req, busy, done, aborted, err}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int r, s, ri, cr, a, w, ab, gd, ak,
                       input int ei, el, eo, erq, eb, ed, eab, ee);
        vec_t t;
        t.rst    = r[0];
        t.start  = s[0];
        t.reinit = ri[0];
        t.cr     = cr[2:0];
        t.addr   = a[7:0];
        t.wc     = w[7:0];
        t.abort  = ab[0];
        t.gd     = gd[0];
        t.ack    = ak[0];
        t.exp    = {ei[2:0], el[7:0], eo[0], erq[0], eb[0], ed[0], eab[0], ee[0]};
        tbl.push_back(t);
    endtask

    function automatic logic [16:0] outs();
        return {instr, load_data, load_oe, xfer_req, busy, done, aborted, err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    initial begin
        int enct;
        bit seen_done;

        rst_n = 1'b0; start = 1'b0; cfg_reinit = 1'b0; cfg_cr = 3'b0; cfg_addr = 8'h0;
        cfg_wc = 8'h0; abort = 1'b0; gen_done = 1'b0; xfer_ack = 1'b0;

        // Full setup, cr=000 addr=0x10 wc=3, ack every RUN cycle
        add(1,1,0,0,'h10,3,0,0,0, 1,'h00,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    0,'h00,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    5,'h10,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    6,'h03,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,1,0,    1,'h00,0,0,1,1,0,0);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,0,0);
        // Reinit, wc=2, ack on alternate cycles
        add(1,1,1,0,0,2,0,0,0,    1,'h00,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    4,'h00,0,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,1,0,    1,'h00,0,0,1,1,0,0);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,0,0);
        // DONE mismatch, cr=101 (mode 01 skips early check), wc=4, gen_done low at FINISH
        add(1,1,0,5,'h20,4,0,0,0, 1,'h00,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    0,'h05,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    5,'h20,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    6,'h04,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,1,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,0,1,1,0,0);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,0,1);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,0,1);
        add(1,1,1,0,0,1,0,0,0,    1,'h00,0,0,0,0,0,1);
        add(1,0,0,0,0,0,0,0,0,    4,'h00,0,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,1,0,    1,'h00,0,0,1,1,0,0);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,0,0);
        // Abort coincident with the 2nd ack
        add(1,1,0,0,'h40,5,0,0,0, 1,'h00,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    0,'h00,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    5,'h40,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    6,'h05,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,1,0,1,    1,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,1,0);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,0,0);
        // Asynchronous reset during LD_AR, then a clean full setup
        add(1,1,0,0,'h33,2,0,0,0, 1,'h00,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    0,'h00,1,0,1,0,0,0);
        add(0,0,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,0,0);
        add(0,1,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,0,0);
        add(1,1,0,2,'h77,1,0,0,0, 1,'h00,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    0,'h02,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    5,'h77,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    6,'h01,1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,1,0,    1,'h00,0,0,1,1,0,0);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,0,0);
        // Mode 00: early gen_done during RUN sets err
        add(1,1,1,0,0,2,0,0,0,    1,'h00,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,    4,'h00,0,0,1,0,0,0);
        add(1,0,0,0,0,0,0,1,0,    1,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,1);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,1);
        add(1,0,0,0,0,0,0,1,0,    1,'h00,0,0,1,1,0,1);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,0,1);
        // start and abort together in IDLE: start wins
        add(1,1,1,0,0,1,1,0,0,    1,'h00,0,0,0,0,0,1);
        add(1,0,0,0,0,0,0,0,0,    4,'h00,0,0,1,0,0,0);
        add(1,0,0,0,0,0,0,0,1,    7,'h00,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,1,0,    1,'h00,0,0,1,1,0,0);
        add(1,0,0,0,0,0,0,0,0,    1,'h00,0,0,0,0,0,0);

        #2;
        check("reset_state", 32'(outs()), 32'({3'b001, 8'h00, 6'b0}));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n      = tbl[i].rst;
            start      = tbl[i].start;
            cfg_reinit = tbl[i].reinit;
            cfg_cr     = tbl[i].cr;
            cfg_addr   = tbl[i].addr;
            cfg_wc     = tbl[i].wc;
            abort      = tbl[i].abort;
            gen_done   = tbl[i].gd;
            xfer_ack   = tbl[i].ack;
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Zero count: 256 ENCTs, gen_done high only in FINISH
        @(posedge clk);
        #1;
        start = 1'b1; cfg_reinit = 1'b0; cfg_cr = 3'b000; cfg_addr = 8'h00; cfg_wc = 8'h00;
        abort = 1'b0; gen_done = 1'b0; xfer_ack = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        xfer_ack = 1'b1;
        enct = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 300 && !seen_done; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            gen_done = (enct == 256);
            @(negedge clk);
            if (instr == 3'b111) enct++;
            if (done) seen_done = 1'b1;
        end
        check("zero_wc_done_seen", 32'(seen_done), 32'd1);
        check("zero_wc_enct_count", enct, 32'd256);
        @(posedge clk);
        #1;
        xfer_ack = 1'b0;
        gen_done = 1'b0;
        @(negedge clk);
        check("zero_wc_err", 32'(err), 32'd0);
        check("zero_wc_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
